// File: rtl/dual_port_bram_request_arbiter.sv
//==============================================================================
// Module   : dual_port_bram_request_arbiter
// Brief    : Round-robin arbiter sharing one BRAM port among NUM_REQ requesters,
//            routing read responses back in issue order via an in-flight ID queue.
//            Optional macro ARB_GRANT_COUNT_EN adds per-requester grant counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dual_port_bram_request_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_read,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_byte_en,
    input  logic [NUM_REQ*ADDRESS_BITS-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [DATA_WIDTH-1:0]          resp_data,
    output logic [ADDRESS_BITS-1:0]        resp_address,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [DATA_WIDTH/8-1:0]        mem_byte_en,
    output logic [ADDRESS_BITS-1:0]        mem_address,
    output logic [DATA_WIDTH-1:0]          mem_data,
    input  logic [DATA_WIDTH-1:0]          mem_data_in,
    input  logic [ADDRESS_BITS-1:0]        mem_address_in,
    input  logic                           mem_valid,
    input  logic                           mem_ready,
`ifdef ARB_GRANT_COUNT_EN
    output logic [NUM_REQ*16-1:0]          grant_count,
`endif
    output logic                           err_unexpected_resp
);

    localparam int c_BE_W  = DATA_WIDTH / 8;
    localparam int c_ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_QP_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [c_ID_W:0]    c_NUM_REQ_V = (c_ID_W + 1)'(NUM_REQ);
    localparam logic [c_ID_W-1:0]  c_LAST_ID   = c_ID_W'(NUM_REQ - 1);
    localparam logic [c_QP_W-1:0]  c_Q_LAST    = c_QP_W'(MAX_OUTSTANDING - 1);
    localparam logic [c_CNT_W-1:0] c_Q_FULL    = c_CNT_W'(MAX_OUTSTANDING);

    logic [c_ID_W-1:0]       r_rr_ptr;
    logic [c_ID_W-1:0]       r_id_q [MAX_OUTSTANDING];
    logic [c_QP_W-1:0]       r_head;
    logic [c_QP_W-1:0]       r_tail;
    logic [c_CNT_W-1:0]      r_count;
    logic                    r_err;

    logic [NUM_REQ-1:0]      w_active;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_grant;
    logic [c_ID_W-1:0]       w_gnt_id;
    logic [c_ID_W:0]         w_scan;
    logic                    w_push;
    logic                    w_pop;

    logic [c_BE_W-1:0]       w_be_arr   [NUM_REQ];
    logic [ADDRESS_BITS-1:0] w_addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_be_arr[gi]   = req_byte_en[gi*c_BE_W +: c_BE_W];
            assign w_addr_arr[gi] = req_address[gi*ADDRESS_BITS +: ADDRESS_BITS];
            assign w_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_active = req_read | req_write;
    assign w_full   = (r_count == c_Q_FULL);
    assign w_empty  = (r_count == '0);

    // Scan from the round-robin pointer; reads are ineligible while the queue is full.
    always_comb begin
        w_grant  = 1'b0;
        w_gnt_id = '0;
        w_scan   = '0;
        if (mem_ready && !reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_scan = {1'b0, r_rr_ptr} + (c_ID_W + 1)'(k);
                if (w_scan >= c_NUM_REQ_V) begin
                    w_scan = w_scan - c_NUM_REQ_V;
                end
                if (!w_grant && w_active[w_scan[c_ID_W-1:0]]
                    && !(req_read[w_scan[c_ID_W-1:0]] && w_full)) begin
                    w_grant  = 1'b1;
                    w_gnt_id = w_scan[c_ID_W-1:0];
                end
            end
        end
    end

    assign w_push = w_grant && req_read[w_gnt_id];
    assign w_pop  = mem_valid && !w_empty;

    always_comb begin
        req_ready   = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_byte_en = '0;
        mem_address = '0;
        mem_data    = '0;
        if (w_grant) begin
            req_ready[w_gnt_id] = 1'b1;
            mem_read            = req_read[w_gnt_id];
            mem_write           = req_write[w_gnt_id];
            mem_byte_en         = w_be_arr[w_gnt_id];
            mem_address         = w_addr_arr[w_gnt_id];
            mem_data            = w_data_arr[w_gnt_id];
        end
    end

    always_comb begin
        resp_valid   = '0;
        resp_data    = '0;
        resp_address = '0;
        if (w_pop) begin
            resp_valid[r_id_q[r_head]] = 1'b1;
            resp_data                  = mem_data_in;
            resp_address               = mem_address_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= (w_gnt_id == c_LAST_ID) ? '0 : w_gnt_id + 1'b1;
            end
            if (w_push) begin
                r_tail <= (r_tail == c_Q_LAST) ? '0 : r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= (r_head == c_Q_LAST) ? '0 : r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (mem_valid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // Queue storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_id_q[r_tail] <= w_gnt_id;
        end
    end

    assign err_unexpected_resp = r_err;

`ifdef ARB_GRANT_COUNT_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (w_grant && (w_gnt_id == c_ID_W'(gi)) && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign grant_count[gi*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule

`default_nettype wire
